// File: rtl/regram_sched_if.sv
// rtl/regram_sched_if.sv - bundle of write-back, operand request/response, flush and RAM port signals
interface regram_sched_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          req_valid;
    logic          req_ready;
    logic          re1;
    logic          re2;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic          rsp_valid;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          flush_req;
    logic          flush_done;
    logic [AW-1:0] ram_addr_a;
    logic [AW-1:0] ram_addr_b;
    logic          ram_rden_a;
    logic          ram_rden_b;
    logic          ram_wren_b;
    logic [DW-1:0] ram_data_b;
    logic [DW-1:0] ram_q_a;
    logic [DW-1:0] ram_q_b;

    modport slave (
        input  wb_we, wb_waddr, wb_wdata, req_valid, re1, re2, raddr1, raddr2,
               flush_req, ram_q_a, ram_q_b,
        output req_ready, rsp_valid, rdata1, rdata2, flush_done,
               ram_addr_a, ram_addr_b, ram_rden_a, ram_rden_b, ram_wren_b, ram_data_b
    );

    modport master (
        output wb_we, wb_waddr, wb_wdata, req_valid, re1, re2, raddr1, raddr2,
               flush_req, ram_q_a, ram_q_b,
        input  req_ready, rsp_valid, rdata1, rdata2, flush_done,
               ram_addr_a, ram_addr_b, ram_rden_a, ram_rden_b, ram_wren_b, ram_data_b
    );
endinterface

// File: rtl/regram_sched.sv
// rtl/regram_sched.sv - reg_ram port scheduler: 2-entry write queue, paired operand reads, forwarding, flush
module regram_sched #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input logic           clk,
    input logic           rst,
    regram_sched_if.slave bus
);
    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t        r_state;
    logic [1:0]    r_count;
    logic [AW-1:0] r_wq_addr [2];
    logic [DW-1:0] r_wq_data [2];
    logic          r_rsp_valid;
    logic          r_zero  [2];
    logic          r_hit   [2];
    logic [DW-1:0] r_fdata [2];

    logic          w_ready;
    logic          w_accept;
    logic          w_b_read;
    logic          w_deq;
    logic          w_enq;
    logic [AW-1:0] w_ra    [2];
    logic          w_re    [2];
    logic          w_hit   [2];
    logic          w_zero  [2];
    logic [DW-1:0] w_fdata [2];
    logic [DW-1:0] w_q     [2];
    logic [DW-1:0] w_rdata [2];

    assign w_ready  = !rst && !bus.flush_req && (r_count != 2'd2) && (r_state == S_IDLE);
    assign w_accept = bus.req_valid && w_ready;
    assign w_b_read = w_accept && bus.re2;
    // Port B drains the queue whenever the read-2 operand does not claim it.
    assign w_deq    = !rst && !w_b_read && (r_count != 2'd0);
    assign w_enq    = bus.wb_we && (bus.wb_waddr != '0);

    // Later overrides win: oldest entry, then newest entry, then the same-cycle write.
    always_comb begin
        w_ra[0] = bus.raddr1;
        w_ra[1] = bus.raddr2;
        w_re[0] = bus.re1;
        w_re[1] = bus.re2;
        for (int i = 0; i < 2; i++) begin
            w_hit[i]   = 1'b0;
            w_fdata[i] = '0;
            if (r_count != 2'd0 && r_wq_addr[0] == w_ra[i]) begin
                w_hit[i]   = 1'b1;
                w_fdata[i] = r_wq_data[0];
            end
            if (r_count == 2'd2 && r_wq_addr[1] == w_ra[i]) begin
                w_hit[i]   = 1'b1;
                w_fdata[i] = r_wq_data[1];
            end
            if (w_enq && bus.wb_waddr == w_ra[i]) begin
                w_hit[i]   = 1'b1;
                w_fdata[i] = bus.wb_wdata;
            end
            w_zero[i] = !w_re[i] || (w_ra[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= 2'd0;
            r_rsp_valid <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_wq_addr[i] <= '0;
                r_wq_data[i] <= '0;
                r_zero[i]    <= 1'b1;
                r_hit[i]     <= 1'b0;
                r_fdata[i]   <= '0;
            end
        end else begin
            case ({w_enq, w_deq})
                2'b01: begin
                    r_wq_addr[0] <= r_wq_addr[1];
                    r_wq_data[0] <= r_wq_data[1];
                    r_count      <= r_count - 2'd1;
                end
                2'b10: begin
                    r_wq_addr[r_count[0]] <= bus.wb_waddr;
                    r_wq_data[r_count[0]] <= bus.wb_wdata;
                    r_count               <= r_count + 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_wq_addr[0] <= r_wq_addr[1];
                        r_wq_data[0] <= r_wq_data[1];
                        r_wq_addr[1] <= bus.wb_waddr;
                        r_wq_data[1] <= bus.wb_wdata;
                    end else begin
                        r_wq_addr[0] <= bus.wb_waddr;
                        r_wq_data[0] <= bus.wb_wdata;
                    end
                end
                default: ;
            endcase

            case (r_state)
                S_IDLE:  if (r_count == 2'd2 || bus.flush_req) r_state <= S_DRAIN;
                S_DRAIN: if (r_count == 2'd0 && !bus.flush_req) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            r_rsp_valid <= w_accept;
            if (w_accept) begin
                for (int i = 0; i < 2; i++) begin
                    r_zero[i]  <= w_zero[i];
                    r_hit[i]   <= w_hit[i];
                    r_fdata[i] <= w_fdata[i];
                end
            end
        end
    end

    always_comb begin
        w_q[0] = bus.ram_q_a;
        w_q[1] = bus.ram_q_b;
        for (int i = 0; i < 2; i++) begin
            w_rdata[i] = '0;
            if (r_rsp_valid && !r_zero[i])
                w_rdata[i] = r_hit[i] ? r_fdata[i] : w_q[i];
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rdata1     = w_rdata[0];
    assign bus.rdata2     = w_rdata[1];
    assign bus.flush_done = !rst && (r_state == S_DRAIN) && (r_count == 2'd0) && bus.flush_req;
    assign bus.ram_addr_a = rst ? '0 : bus.raddr1;
    assign bus.ram_rden_a = w_accept && bus.re1;
    assign bus.ram_addr_b = rst ? '0 : (w_b_read ? bus.raddr2 : r_wq_addr[0]);
    assign bus.ram_rden_b = w_b_read;
    assign bus.ram_wren_b = w_deq;
    assign bus.ram_data_b = rst ? '0 : r_wq_data[0];
endmodule

// File: doc/regram_sched.md
# regram_sched

Port scheduler between the ID/WB stages and the dual-port `reg_ram` macro that backs the register file. It buffers write-back writes in a 2-entry write queue, and issues paired operand reads through a valid/ready handshake. It arbitrates RAM port B between the read-2 operand and draining queued writes, and forwards pending writes so reads never return stale data. It also provides a flush sequence that empties the write queue before halt or debug entry.

## Interface
- DW, 32, data width (`RegBus`)
- AW, 5, register address width (`RegAddrBus`); write queue depth fixed at 2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_we  in  1  write-back write strobe; always accepted, no backpressure
- wb_waddr  in  AW  write address
- wb_wdata  in  DW  write data
- req_valid  in  1  operand read request
- req_ready  out  1  request accepted when req_valid & req_ready
- re1, re2  in  1 each  operand enables
- raddr1, raddr2  in  AW each  operand addresses
- rsp_valid  out  1  one-cycle pulse carrying operand data
- rdata1, rdata2  out  DW each  operand data
- flush_req  in  1  level; request a full write-queue drain
- flush_done  out  1  high while flush_req=1 and the queue is empty
- ram_addr_a, ram_addr_b  out  AW each  RAM addresses
- ram_rden_a, ram_rden_b, ram_wren_b  out  1 each  RAM strobes
- ram_data_b  out  DW  RAM write data
- ram_q_a, ram_q_b  in  DW each  RAM read data; registered, 1-cycle latency

## Operation
- Write queue (wq): FIFO, count 0..2.
  - Enqueue when wb_we=1 and wb_waddr!=0. Writes to x0 are dropped.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- req_ready = !flush_req && count<2 && state!=DRAIN.
- Accept cycle T:
  - Port A: ram_addr_a=raddr1, ram_rden_a=re1.
  - Port B: if re2, then ram_addr_b=raddr2, ram_rden_b=1, ram_wren_b=0, and no dequeue this cycle.
- Port B otherwise: if count>0, drive ram_wren_b=1 with the wq head address/data and dequeue at the clock edge. If count=0, port B is idle.
- Forwarding, evaluated per operand at T and registered with the request:
  - Priority: incoming wb write at T > newest wq entry > oldest wq entry (including an entry being drained at T) > RAM q.
  - Address 0 or re=0 yields 0 and takes precedence over everything.
- Response at T+1: rsp_valid=1, and rdata = forwarded value or ram_q. Back-to-back accepts are allowed (one response per cycle). There is no response backpressure.
- FSM states:
  - IDLE → DRAIN when count=2 or flush_req=1.
  - DRAIN → IDLE when count=0 and flush_req=0.
  - In DRAIN, req_ready=0 and port B writes every cycle.
  - flush_done=1 in DRAIN when count=0 and flush_req=1.
- Overflow cannot occur: a port-B read is only issued when count≤1, and at count=2 every cycle dequeues.

## Timing
- Reset values: count=0, state=IDLE, rsp_valid=0, rdata1/rdata2=0, flush_done=0, all RAM strobes=0, RAM addresses/data=0.
- Reset mid-operation discards queued writes and any in-flight response. rsp_valid is 0 the cycle after rst.
- Read latency: accept at T, data at T+1.
- Write-to-RAM latency: at least 1 cycle after enqueue. It is delayed further by each intervening re2 read.
- A write enqueued at T is visible to a read accepted at T (via forwarding).
- Flush latency: at most 2 cycles from flush_req to flush_done when no writes arrive during the flush.

## Test plan
- Write x5=0xDEADBEEF at T0 with no reads; read x5 at T3 → RAM written at T1; rsp at T4 with rdata1=0xDEADBEEF taken from RAM q.
- Same-cycle write x7=0x11 and read raddr1=7, raddr2=7 → rsp next cycle with rdata1=rdata2=0x11 (forwarded).
- Continuous re2 reads while writing x1..x3 on consecutive cycles → req_ready drops when count=2; state goes to DRAIN; all three RAM writes occur in order; no write is lost.
- Two queued writes to x9 (0xA then 0xB) then read x9 → rdata=0xB (newest-entry priority).
- Write x0=0xFF, read raddr1=0 with re1=1, and read with re2=0 → rdata1=0, rdata2=0, no enqueue.
- flush_req with count=2 → req_ready=0; two port-B writes; flush_done rises 2 cycles after flush_req. Apply rst mid-drain → count=0 and no further RAM writes.
